// File: rtl/fetch_pkg.sv
// Shared pipeline definitions for the fetch stage: default widths, fetch FSM
// states and the IF/ID bundle layout.
package fetch_pkg;

  localparam int unsigned DEF_PC_W   = 32;
  localparam int unsigned DEF_INST_W = 16;

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_IMM   = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic                  valid;
    logic [DEF_INST_W-1:0] inst;
    logic [DEF_INST_W-1:0] imm;
    logic [DEF_PC_W-1:0]   pc;
  } if_id_t;

  // All-zero word doubles as the NOP that decode already recognises
  localparam if_id_t IF_ID_BUBBLE = '0;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register; bubble load has priority over a normal load,
// and with neither asserted the register holds.
module if_id_reg #(
  parameter int unsigned PC_W   = fetch_pkg::DEF_PC_W,
  parameter int unsigned INST_W = fetch_pkg::DEF_INST_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              bubble,
  input  logic [INST_W-1:0] d_inst,
  input  logic [INST_W-1:0] d_imm,
  input  logic [PC_W-1:0]   d_pc,
  output logic              valid,
  output logic [INST_W-1:0] inst,
  output logic [INST_W-1:0] imm,
  output logic [PC_W-1:0]   pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      inst  <= '0;
      imm   <= '0;
      pc    <= '0;
    end else if (bubble) begin
      valid <= 1'b0;
      inst  <= '0;
      imm   <= '0;
      pc    <= '0;
    end else if (load) begin
      valid <= 1'b1;
      inst  <= d_inst;
      imm   <= d_imm;
      pc    <= d_pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, one/two-word instruction assembly and IF/ID register.
// Optional load-use stall counter enabled by defining FETCH_STALL_CNT_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned     PC_W     = DEF_PC_W,
  parameter int unsigned     INST_W   = DEF_INST_W,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     IMM_BIT  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_nop_LD,
  input  logic              flush,
  input  logic [PC_W-1:0]   flush_pc,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_data,
  output logic              if_id_valid,
  output logic [INST_W-1:0] if_id_inst,
  output logic [INST_W-1:0] if_id_imm,
  output logic [PC_W-1:0]   if_id_pc
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  fetch_state_e      state, state_nxt;
  logic [PC_W-1:0]   pc, pc_nxt, pc_inc;
  logic [INST_W-1:0] held, held_nxt;
  logic              id_load, id_bubble;
  logic [INST_W-1:0] id_inst, id_imm;

  assign imem_addr = pc;
  assign pc_inc    = pc + PC_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
      held  <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      held  <= held_nxt;
    end
  end

  // Priority: flush, then load-use stall, then normal advance
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    held_nxt  = held;
    id_load   = 1'b0;
    id_bubble = 1'b0;
    id_inst   = '0;
    id_imm    = '0;
    if (flush) begin
      pc_nxt    = flush_pc;
      held_nxt  = '0;
      state_nxt = S_FETCH;
      id_bubble = 1'b1;
    end else if (!fetch_nop_LD) begin
      pc_nxt = pc_inc;
      case (state)
        S_FETCH: begin
          if (imem_data[IMM_BIT]) begin
            held_nxt  = imem_data;
            state_nxt = S_IMM;
            id_bubble = 1'b1;
          end else begin
            id_load = 1'b1;
            id_inst = imem_data;
          end
        end
        S_IMM: begin
          id_load   = 1'b1;
          id_inst   = held;
          id_imm    = imem_data;
          held_nxt  = '0;
          state_nxt = S_FETCH;
        end
        default: state_nxt = S_FETCH;
      endcase
    end
  end

  if_id_reg #(
    .PC_W   (PC_W),
    .INST_W (INST_W)
  ) u_if_id (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (id_load),
    .bubble (id_bubble),
    .d_inst (id_inst),
    .d_imm  (id_imm),
    .d_pc   (pc_inc),
    .valid  (if_id_valid),
    .inst   (if_id_inst),
    .imm    (if_id_imm),
    .pc     (if_id_pc)
  );

`ifdef FETCH_STALL_CNT_EN
  // Counts stall cycles that were not overridden by a flush; saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (fetch_nop_LD && !flush && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, reset corner
// cases and randomized stall/flush traffic against an instruction-stream model.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_nop_LD;
  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] imem_addr;
  logic [15:0] imem_data;
  logic        if_id_valid;
  logic [15:0] if_id_inst;
  logic [15:0] if_id_imm;
  logic [31:0] if_id_pc;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  logic [15:0] mem [0:255];

  fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_nop_LD (fetch_nop_LD),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .if_id_valid  (if_id_valid),
    .if_id_inst   (if_id_inst),
    .if_id_imm    (if_id_imm),
    .if_id_pc     (if_id_pc)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory: 256 words at the bottom, one word at the top address, zero elsewhere
  assign imem_data = (imem_addr < 32'd256) ? mem[imem_addr[7:0]] :
                     ((imem_addr == 32'hFFFF_FFFF) ? 16'h1110 : 16'h0000);

  function automatic logic [15:0] mrd(input logic [31:0] a);
    if (a < 32'd256) return mem[a[7:0]];
    if (a == 32'hFFFF_FFFF) return 16'h1110;
    return 16'h0000;
  endfunction

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic if_id_t mk(input logic v, input logic [15:0] i, input logic [15:0] m,
                                input logic [31:0] p);
    if_id_t r;
    r.valid = v; r.inst = i; r.imm = m; r.pc = p;
    return r;
  endfunction

  function automatic logic [127:0] dut_view();
    return 128'({if_id_valid, if_id_inst, if_id_imm, if_id_pc, imem_addr});
  endfunction

  function automatic logic [127:0] exp_view(input if_id_t e, input logic [31:0] addr);
    return 128'({e, addr});
  endfunction

  typedef struct {
    logic        stall;
    logic        flush;
    logic [31:0] fpc;
    if_id_t      exp;
    logic [31:0] exp_addr;
    logic [15:0] exp_cnt;
  } vec_t;

  function automatic vec_t row(input logic s, input logic f, input logic [31:0] fp,
                               input if_id_t e, input logic [31:0] a, input logic [15:0] c);
    vec_t r;
    r.stall = s; r.flush = f; r.fpc = fp; r.exp = e; r.exp_addr = a; r.exp_cnt = c;
    return r;
  endfunction

  // Behavioural model: words fetched go into a queue until they form an instruction
  logic [31:0] m_pc;
  logic [15:0] m_cnt;
  if_id_t      m_out;
  logic [15:0] pend [$];

  task automatic model_reset();
    m_pc = 32'd0; m_cnt = 16'd0; m_out = IF_ID_BUBBLE; pend.delete();
  endtask

  task automatic model_edge(input logic st, input logic fl, input logic [31:0] fp);
    if (fl) begin
      m_pc = fp; pend.delete(); m_out = IF_ID_BUBBLE;
    end else if (st) begin
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else begin
      pend.push_back(mrd(m_pc));
      m_pc = m_pc + 32'd1;
      if (pend[0][0] == 1'b0 || pend.size() == 2) begin
        m_out = mk(1'b1, pend[0], (pend.size() == 2) ? pend[1] : 16'h0, m_pc);
        pend.delete();
      end else begin
        m_out = IF_ID_BUBBLE;
      end
    end
  endtask

  task automatic step(input logic st, input logic fl, input logic [31:0] fp);
    fetch_nop_LD = st; flush = fl; flush_pc = fp;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [22];

  initial begin
    rst_n = 1'b0; fetch_nop_LD = 1'b0; flush = 1'b0; flush_pc = 32'd0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'h1000; mem[1] = 16'h2000; mem[2] = 16'h3000; mem[3] = 16'h4000;
    mem[4] = 16'h0001; mem[5] = 16'hBEEF; mem[6] = 16'h5000; mem[7] = 16'h6000;
    mem[8] = 16'h7000; mem[9] = 16'h8000; mem[10] = 16'h9000; mem[11] = 16'h0003;
    mem[12] = 16'hCAFE; mem[13] = 16'hA000; mem[14] = 16'h0005; mem[15] = 16'hD00D;
    mem[64] = 16'h1234;

    tbl[0]  = row(0, 0, 0, mk(1, 16'h1000, 0, 1), 1, 0);
    tbl[1]  = row(0, 0, 0, mk(1, 16'h2000, 0, 2), 2, 0);
    tbl[2]  = row(0, 0, 0, mk(1, 16'h3000, 0, 3), 3, 0);
    tbl[3]  = row(0, 0, 0, mk(1, 16'h4000, 0, 4), 4, 0);
    tbl[4]  = row(0, 0, 0, IF_ID_BUBBLE, 5, 0);
    tbl[5]  = row(0, 0, 0, mk(1, 16'h0001, 16'hBEEF, 6), 6, 0);
    tbl[6]  = row(0, 0, 0, mk(1, 16'h5000, 0, 7), 7, 0);
    tbl[7]  = row(0, 0, 0, mk(1, 16'h6000, 0, 8), 8, 0);
    tbl[8]  = row(0, 0, 0, mk(1, 16'h7000, 0, 9), 9, 0);
    tbl[9]  = row(1, 0, 0, mk(1, 16'h7000, 0, 9), 9, 1);
    tbl[10] = row(0, 0, 0, mk(1, 16'h8000, 0, 10), 10, 1);
    tbl[11] = row(0, 0, 0, mk(1, 16'h9000, 0, 11), 11, 1);
    tbl[12] = row(0, 0, 0, IF_ID_BUBBLE, 12, 1);
    tbl[13] = row(1, 0, 0, IF_ID_BUBBLE, 12, 2);
    tbl[14] = row(1, 0, 0, IF_ID_BUBBLE, 12, 3);
    tbl[15] = row(0, 0, 0, mk(1, 16'h0003, 16'hCAFE, 13), 13, 3);
    tbl[16] = row(0, 0, 0, mk(1, 16'hA000, 0, 14), 14, 3);
    tbl[17] = row(0, 0, 0, IF_ID_BUBBLE, 15, 3);
    tbl[18] = row(1, 1, 32'h40, IF_ID_BUBBLE, 32'h40, 3);
    tbl[19] = row(0, 0, 0, mk(1, 16'h1234, 0, 32'h41), 32'h41, 3);
    tbl[20] = row(0, 1, 32'hFFFF_FFFF, IF_ID_BUBBLE, 32'hFFFF_FFFF, 3);
    tbl[21] = row(0, 0, 0, mk(1, 16'h1110, 0, 0), 0, 3);

    // Reset state
    #12;
    chk("reset_state", dut_view(), exp_view(IF_ID_BUBBLE, 32'd0));
`ifdef FETCH_STALL_CNT_EN
    chk("reset_cnt", 128'(stall_cnt), 128'd0);
`endif
    @(negedge clk); rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].stall, tbl[i].flush, tbl[i].fpc);
      chk($sformatf("vec%0d", i), dut_view(), exp_view(tbl[i].exp, tbl[i].exp_addr));
`ifdef FETCH_STALL_CNT_EN
      chk($sformatf("vec%0d_cnt", i), 128'(stall_cnt), 128'(tbl[i].exp_cnt));
`endif
    end

    // Async reset in the middle of a two-word fetch drops the held opcode
    step(0, 1, 32'd4);
    step(0, 0, 0);
    chk("pre_reset_s_imm", dut_view(), exp_view(IF_ID_BUBBLE, 32'd5));
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset", dut_view(), exp_view(IF_ID_BUBBLE, 32'd0));
`ifdef FETCH_STALL_CNT_EN
    chk("async_reset_cnt", 128'(stall_cnt), 128'd0);
`endif
    @(negedge clk); rst_n = 1'b1;
    step(0, 0, 0);
    chk("restart_after_reset", dut_view(), exp_view(mk(1, 16'h1000, 0, 1), 32'd1));

    // Randomized traffic against the model
    @(negedge clk); rst_n = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    for (int n = 0; n < 600; n++) begin
      logic st, fl;
      logic [31:0] fp;
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 15) == 0);
      fp = 32'($urandom_range(0, 200));
      step(st, fl, fp);
      model_edge(st, fl, fp);
      if (n % 8 == 0 || dut_view() !== exp_view(m_out, m_pc))
        chk($sformatf("rand%0d", n), dut_view(), exp_view(m_out, m_pc));
`ifdef FETCH_STALL_CNT_EN
      if (n % 50 == 0 || stall_cnt !== m_cnt)
        chk($sformatf("rand%0d_cnt", n), 128'(stall_cnt), 128'(m_cnt));
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
